// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the centre-aligned PWM bridge.
//   - CW_DEF / HALF_PERIOD_DEF : default counter width and carrier half period
//   - bridge_state_t           : per-leg gate-drive state
// Optional feature macro: PWM_BRIDGE_DEADTIME_EN adds the dead-band states.
package pwm_pkg;

  localparam int unsigned CW_DEF          = 21;
  localparam int unsigned HALF_PERIOD_DEF = 500;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_A_ON    = 3'd1,
    ST_B_ON    = 3'd2,
    ST_TRIP    = 3'd3
`ifdef PWM_BRIDGE_DEADTIME_EN
    ,
    ST_DEAD_AB = 3'd4,
    ST_DEAD_BA = 3'd5
`endif
  } bridge_state_t;

endpackage

// File: rtl/pwm_deadband.sv
// pwm_deadband: gate-drive state machine for one bridge leg.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_trip      : force both gates off (protection or latched fault)
//   i_pos0      : this leg's position counter is at 0 (period start)
//   i_raw       : raw high-side demand from the carrier compare
//   o_pwmA/B    : registered high-side / low-side gate outputs
// Macro PWM_BRIDGE_DEADTIME_EN: when defined, every A<->B handover passes
// through a DEADTIME-cycle interval with both gates low; otherwise B is the
// complement of A whenever the leg is conducting.
module pwm_deadband
  import pwm_pkg::*;
`ifdef PWM_BRIDGE_DEADTIME_EN
#(
  parameter int unsigned DEADTIME = 10
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_trip,
  input  logic i_pos0,
  input  logic i_raw,
  output logic o_pwmA,
  output logic o_pwmB
);

  bridge_state_t r_state;
  bridge_state_t w_next;
  logic          r_pwmA;
  logic          r_pwmB;

`ifdef PWM_BRIDGE_DEADTIME_EN
  localparam logic [7:0] LP_DT_LAST = (DEADTIME == 0) ? 8'd0 : 8'(DEADTIME - 1);
  logic [7:0] r_dcnt;
  logic [7:0] w_dcnt_next;
`endif

  always_comb begin
    w_next = r_state;
`ifdef PWM_BRIDGE_DEADTIME_EN
    w_dcnt_next = r_dcnt;
`endif
    if (i_trip) begin
      w_next = ST_TRIP;
    end else begin
      case (r_state)
        ST_TRIP: w_next = ST_OFF;
        // Idle for at least a full dead interval, so conduction starts directly.
        ST_OFF: if (i_pos0) w_next = i_raw ? ST_A_ON : ST_B_ON;
`ifdef PWM_BRIDGE_DEADTIME_EN
        ST_A_ON: begin
          if (!i_raw) begin
            if (DEADTIME == 0) begin
              w_next = ST_B_ON;
            end else begin
              w_next      = ST_DEAD_AB;
              w_dcnt_next = LP_DT_LAST;
            end
          end
        end
        ST_B_ON: begin
          if (i_raw) begin
            if (DEADTIME == 0) begin
              w_next = ST_A_ON;
            end else begin
              w_next      = ST_DEAD_BA;
              w_dcnt_next = LP_DT_LAST;
            end
          end
        end
        // A demand reversal only retargets the pending handover; the dead
        // count keeps running so both gates stay low for the full interval.
        ST_DEAD_AB, ST_DEAD_BA: begin
          if (r_dcnt == 8'd0) begin
            w_next = i_raw ? ST_A_ON : ST_B_ON;
          end else begin
            w_next      = i_raw ? ST_DEAD_BA : ST_DEAD_AB;
            w_dcnt_next = r_dcnt - 8'd1;
          end
        end
`else
        ST_A_ON, ST_B_ON: w_next = i_raw ? ST_A_ON : ST_B_ON;
`endif
        default: w_next = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_pwmA  <= 1'b0;
      r_pwmB  <= 1'b0;
`ifdef PWM_BRIDGE_DEADTIME_EN
      r_dcnt  <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_pwmA  <= (w_next == ST_A_ON);
      r_pwmB  <= (w_next == ST_B_ON);
`ifdef PWM_BRIDGE_DEADTIME_EN
      r_dcnt  <= w_dcnt_next;
`endif
    end
  end

  assign o_pwmA = r_pwmA;
  assign o_pwmB = r_pwmB;

endmodule

// File: rtl/pwm_bridge_multi.sv
// pwm_bridge_multi: N_CH phase-shifted, centre-aligned PWM bridge legs with
// shadowed duty, trip latch and period sync.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   protection  : active-high trip request (forces all gates off next edge)
//   fault_clr   : pulse clearing the latched fault while protection is low
//   duty        : per-leg compare value, leg i at [i*CW +: CW]
//   pwmA, pwmB  : high-side / low-side gates per leg
//   fault       : latched trip status
//   sync        : one-cycle pulse while leg 0 is at position 0
// Macro PWM_BRIDGE_DEADTIME_EN: enables the dead-band handover in each leg.
module pwm_bridge_multi
  import pwm_pkg::*;
#(
  parameter int unsigned        N_CH        = 2,
  parameter int unsigned        CW          = CW_DEF,
  parameter int unsigned        HALF_PERIOD = HALF_PERIOD_DEF,
  parameter logic [N_CH*CW-1:0] PHASE       = '0,
  parameter int unsigned        DEADTIME    = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 protection,
  input  logic                 fault_clr,
  input  logic [N_CH*CW-1:0]   duty,
  output logic [N_CH-1:0]      pwmA,
  output logic [N_CH-1:0]      pwmB,
  output logic                 fault,
  output logic                 sync
);

  // One extra bit so a full period (2*HALF_PERIOD) always fits the counter.
  localparam int unsigned      PW          = CW + 1;
  localparam logic [PW-1:0]    LP_POS_LAST = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0]    LP_HALF     = PW'(HALF_PERIOD);
  localparam logic [CW-1:0]    LP_DUTY_MAX = CW'(HALF_PERIOD);

  if (DEADTIME > 255 || HALF_PERIOD < 2 || N_CH < 1 || N_CH > 8) begin : g_bad_params
    $error("pwm_bridge_multi: parameter out of range");
  end

  logic            r_fault;
  logic            r_sync;
  logic            w_trip;
  logic [N_CH-1:0] w_last;

  assign w_trip = protection | r_fault;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [PW-1:0] r_pos;
    logic [CW-1:0] r_duty_act;
    logic [CW-1:0] w_duty_in;
    logic [CW-1:0] w_duty_clamped;
    logic [PW-1:0] w_cnt;
    logic          w_raw;

    assign w_last[g]      = (r_pos == LP_POS_LAST);
    assign w_duty_in      = duty[g*CW +: CW];
    assign w_duty_clamped = (w_duty_in >= LP_DUTY_MAX) ? LP_DUTY_MAX : w_duty_in;
    // Triangle carrier: rises over the first half period, mirrors back down.
    assign w_cnt          = (r_pos < LP_HALF) ? r_pos : (LP_POS_LAST - r_pos);
    assign w_raw          = (w_cnt < {1'b0, r_duty_act});

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pos      <= {1'b0, PHASE[g*CW +: CW]};
        r_duty_act <= '0;
      end else begin
        r_pos <= w_last[g] ? '0 : r_pos + 1'b1;
        // Shadow load on the last position: new duty governs whole periods only.
        if (w_last[g]) r_duty_act <= w_duty_clamped;
      end
    end

    pwm_deadband
`ifdef PWM_BRIDGE_DEADTIME_EN
      #(.DEADTIME(DEADTIME))
`endif
      u_deadband (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_trip (w_trip),
        .i_pos0 (r_pos == '0),
        .i_raw  (w_raw),
        .o_pwmA (pwmA[g]),
        .o_pwmB (pwmB[g])
      );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_fault <= protection | (r_fault & ~fault_clr);
      // Registered so sync is high exactly while leg 0 sits at position 0.
      r_sync  <= w_last[0];
    end
  end

  assign fault = r_fault;
  assign sync  = r_sync;

endmodule

// File: tb/tb_pwm_bridge_multi.sv
module tb_pwm_bridge_multi;

  localparam int NCH = 2;
  localparam int CWB = 21;
  localparam int HP  = 500;
  localparam int PER = 2 * HP;
`ifdef PWM_BRIDGE_DEADTIME_EN
  localparam int MD      = 10;
  localparam int EXP_A1  = 190;
  localparam int EXP_B1  = 790;
  localparam int EXP_A3  = 590;
  localparam int EXP_B3  = 390;
  localparam int EXP_RISE = 911;
`else
  localparam int MD      = 0;
  localparam int EXP_A1  = 200;
  localparam int EXP_B1  = 800;
  localparam int EXP_A3  = 600;
  localparam int EXP_B3  = 400;
  localparam int EXP_RISE = 901;
`endif
  localparam int PH [NCH] = '{0, 500};

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 protection = 1'b0;
  logic                 fault_clr = 1'b0;
  logic [NCH*CWB-1:0]   duty;
  logic [NCH-1:0]       pwmA, pwmB;
  logic                 fault, sync;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pwm_bridge_multi #(
    .N_CH        (NCH),
    .CW          (CWB),
    .HALF_PERIOD (HP),
    .PHASE       ({21'd500, 21'd0}),
    .DEADTIME    (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .protection (protection),
    .fault_clr  (fault_clr),
    .duty       (duty),
    .pwmA       (pwmA),
    .pwmB       (pwmB),
    .fault      (fault),
    .sync       (sync)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=off, 1=running, 2=tripped. While running, a
  // gate is on once its demand has held for MD+1 samples, or for every
  // sample since the leg started conducting.
  int   mpos [NCH];
  int   mduty [NCH];
  int   mode [NCH];
  int   since [NCH];
  int   run_hi [NCH];
  int   run_lo [NCH];
  logic mfault = 1'b0;
  logic msync = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        mpos[c] = PH[c]; mduty[c] = 0; mode[c] = 0;
        since[c] = 0; run_hi[c] = 0; run_lo[c] = 0;
      end
      mfault = 1'b0;
      msync  = 1'b0;
    end else begin
      logic trip;
      trip  = protection | mfault;
      msync = (mpos[0] == PER - 1);
      for (int c = 0; c < NCH; c++) begin
        int  tri_v;
        int  d;
        bit  raw;
        tri_v = (mpos[c] < HP) ? mpos[c] : PER - 1 - mpos[c];
        raw   = (tri_v < mduty[c]);
        if (trip) mode[c] = 2;
        else if (mode[c] == 2) mode[c] = 0;
        else if (mode[c] == 0) begin
          if (mpos[c] == 0) begin
            mode[c] = 1; since[c] = 1;
            run_hi[c] = raw ? 1 : 0;
            run_lo[c] = raw ? 0 : 1;
          end
        end else begin
          since[c]++;
          if (raw) begin run_hi[c]++; run_lo[c] = 0; end
          else     begin run_lo[c]++; run_hi[c] = 0; end
        end
        if (mpos[c] == PER - 1) begin
          d = int'(duty[c*CWB +: CWB]);
          mduty[c] = (d >= HP) ? HP : d;
        end
        mpos[c] = (mpos[c] + 1) % PER;
      end
      mfault = protection ? 1'b1 : (fault_clr ? 1'b0 : mfault);
    end
  end

  function automatic logic exp_gate(int c, bit high_side);
    int r;
    r = high_side ? run_hi[c] : run_lo[c];
    return (mode[c] == 1) && (r > 0) && ((r >= MD + 1) || (r == since[c]));
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {pwmA, pwmB, fault, sync}, 0);
    end else begin
      logic [NCH-1:0] ea, eb;
      for (int c = 0; c < NCH; c++) begin
        ea[c] = exp_gate(c, 1'b1);
        eb[c] = exp_gate(c, 1'b0);
      end
      check("pwmA", pwmA, ea);
      check("pwmB", pwmB, eb);
      check("fault", fault, mfault);
      check("sync", sync, msync);
    end
  end

  task automatic wait_sync(output int n);
    n = 0;
    for (int k = 1; k <= PER + 100; k++) begin
      @(negedge clk);
      if (sync) begin n = k; return; end
    end
    tests++; fails++;
    $display("FAIL sync_timeout: got no sync expected one within %0d cycles", PER + 100);
  endtask

  // Starts at a negedge where leg 0 is at position 0; covers the outputs
  // produced by positions 0..PER-1 of leg 0 and ends at the next position 0.
  task automatic count_period(input int chg_at, input int newd,
                              output int a0, output int b0,
                              output int rise0, output int rise1);
    logic [NCH-1:0] prev;
    a0 = 0; b0 = 0; rise0 = -1; rise1 = -1;
    prev = pwmA;
    for (int k = 1; k <= PER; k++) begin
      @(negedge clk);
      if (k == chg_at) duty = {CWB'(newd), CWB'(newd)};
      if (pwmA[0]) a0++;
      if (pwmB[0]) b0++;
      if (pwmA[0] && !prev[0]) rise0 = k;
      if (pwmA[1] && !prev[1]) rise1 = k;
      prev = pwmA;
    end
  endtask

  initial begin
    int a, b, r0, r1, n;
    duty = {21'd100, 21'd100};
    repeat (5) @(negedge clk);
    check("reset_pwmA_lit", pwmA, 0);
    check("reset_fault_lit", fault, 0);
    rst_n = 1'b1;
    repeat (2200) @(negedge clk);

    // Steady state, duty 100 on both legs.
    wait_sync(n);
    count_period(0, 0, a, b, r0, r1);
    check("steady_pwmA_high", a, EXP_A1);
    check("steady_pwmB_high", b, EXP_B1);
    check("steady_rise_pos", r0, EXP_RISE);
    check("phase_offset", ((r1 - r0) % PER + PER) % PER, 500);

    // Duty change mid-period only affects the following period.
    count_period(200, 300, a, b, r0, r1);
    check("chg_cur_pwmA", a, EXP_A1);
    count_period(0, 0, a, b, r0, r1);
    check("chg_next_pwmA", a, EXP_A3);
    check("chg_next_pwmB", b, EXP_B3);

    // Over-range duty clamps to a continuous high side.
    duty = {21'd600, 21'd600};
    repeat (2200) @(negedge clk);
    wait_sync(n);
    count_period(0, 0, a, b, r0, r1);
    check("clamp_pwmA", a, PER);
    check("clamp_pwmB", b, 0);

    // Trip in the middle of an A_ON pulse.
    duty = {21'd100, 21'd100};
    repeat (2200) @(negedge clk);
    wait_sync(n);
    repeat (50) @(negedge clk);
    check("pre_trip_pwmA0", pwmA[0], 1);
    protection = 1'b1;
    @(negedge clk);
    check("trip_pwmA", pwmA, 0);
    check("trip_pwmB", pwmB, 0);
    check("trip_fault", fault, 1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("clr_blocked_fault", fault, 1);
    protection = 1'b0;
    repeat (3) @(negedge clk);
    check("fault_latched", fault, 1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("fault_cleared", fault, 0);
    check("off_after_clr", {pwmA, pwmB}, 0);
    wait_sync(n);
    repeat (10) @(negedge clk);
    check("resume_pwmA0", pwmA[0], 1);
    check("resume_pwmB0", pwmB[0], 0);

    // Asynchronous reset in mid-period.
    repeat (300) @(negedge clk);
    check("pre_reset_pwmB0", pwmB[0], 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_gates", {pwmA, pwmB}, 0);
    check("async_reset_fault_sync", {fault, sync}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_sync(n);
    check("post_reset_sync_delay", n, PER);
    repeat (1200) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
